// File: rtl/mod_divisor.sv
// Sequential signed restoring divider: magnitudes divided one quotient bit per clock, signs fixed up after.
// Optional MOD_DIVISOR_EARLY_EXIT_EN: skip the iterations when |A| < |B| (results unchanged, latency 2).
module mod_divisor #(
  parameter int WIDTH = 6
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             DIV0,
  output logic             OF_DIV,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, FIN} state_t;

  state_t           state, state_nxt;
  logic             sa, sb, div0_pend, early;
  logic [WIDTH-1:0] a_mag, b_mag, bm, dvd;
  logic [WIDTH:0]   p, p_sh;
  logic [CW-1:0]    cnt;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  // |-2^(W-1)| wraps to the same bit pattern, which reads correctly as unsigned
  assign a_mag = A[WIDTH-1] ? neg(A) : A;
  assign b_mag = B[WIDTH-1] ? neg(B) : B;
  assign p_sh  = (p << 1) | {{WIDTH{1'b0}}, dvd[WIDTH-1]};

`ifdef MOD_DIVISOR_EARLY_EXIT_EN
  assign early = (a_mag < b_mag) && (B != '0);
`else
  assign early = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    case (state)
      IDLE: if (START) state_nxt = ((B == '0) || early) ? SIGN : CALC;
      CALC: begin
        BUSY = 1'b1;
        if (cnt == CW'(1)) state_nxt = SIGN;
      end
      SIGN: begin
        BUSY      = 1'b1;
        state_nxt = FIN;
      end
      FIN: begin
        DONE      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sa        <= 1'b0;
      sb        <= 1'b0;
      div0_pend <= 1'b0;
      bm        <= '0;
      dvd       <= '0;
      p         <= '0;
      cnt       <= '0;
      Q         <= '0;
      R         <= '0;
      DIV0      <= 1'b0;
      OF_DIV    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (START) begin
          sa        <= A[WIDTH-1];
          sb        <= B[WIDTH-1];
          bm        <= b_mag;
          cnt       <= CW'(WIDTH);
          div0_pend <= (B == '0);
          if (early) begin
            dvd <= '0;
            p   <= {1'b0, a_mag};
          end else begin
            dvd <= a_mag;
            p   <= '0;
          end
        end
        CALC: begin
          // dvd doubles as the quotient register: quotient bits enter at the LSB
          if (p_sh >= {1'b0, bm}) begin
            p   <= p_sh - {1'b0, bm};
            dvd <= {dvd[WIDTH-2:0], 1'b1};
          end else begin
            p   <= p_sh;
            dvd <= {dvd[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - CW'(1);
        end
        SIGN: begin
          if (div0_pend) begin
            Q      <= '0;
            R      <= sa ? neg(dvd) : dvd;
            DIV0   <= 1'b1;
            OF_DIV <= 1'b0;
          end else if (sa && sb && (dvd == {1'b1, {(WIDTH-1){1'b0}}})) begin
            Q      <= dvd;
            R      <= '0;
            DIV0   <= 1'b0;
            OF_DIV <= 1'b1;
          end else begin
            Q      <= (sa ^ sb) ? neg(dvd) : dvd;
            R      <= sa ? neg(p[WIDTH-1:0]) : p[WIDTH-1:0];
            DIV0   <= 1'b0;
            OF_DIV <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_divisor.sv
// Directed + random bench for mod_divisor: expected results queued at START, checked at DONE.
module tb_mod_divisor;

  logic       CLK = 1'b0;
  logic       RST_N, START;
  logic [5:0] A, B, Q, R;
  logic       DIV0, OF_DIV, BUSY, DONE;

  typedef struct {
    logic [5:0] q, r;
    logic       div0, ovf;
    int         lat;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0, n_err = 0;

  mod_divisor #(.WIDTH(6)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .A(A), .B(B),
    .Q(Q), .R(R), .DIV0(DIV0), .OF_DIV(OF_DIV), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [5:0] a, input logic [5:0] b, input string tag);
    exp_t m;
    int   ai, bi;
    ai     = $signed(a);
    bi     = $signed(b);
    m.tag  = tag;
    m.div0 = 1'b0;
    m.ovf  = 1'b0;
    m.lat  = 8;
    if (bi == 0) begin
      m.q = '0; m.r = a; m.div0 = 1'b1; m.lat = 2;
    end else if (ai == -32 && bi == -1) begin
      m.q = 6'b100000; m.r = '0; m.ovf = 1'b1;
    end else begin
      m.q = 6'(ai / bi);
      m.r = 6'(ai % bi);
`ifdef MOD_DIVISOR_EARLY_EXIT_EN
      if ((ai < 0 ? -ai : ai) < (bi < 0 ? -bi : bi)) m.lat = 2;
`endif
    end
    return m;
  endfunction

  // One division; START is raised in an IDLE cycle. restart_at re-asserts START mid-op.
  task automatic run_op(input logic [5:0] a, input logic [5:0] b, input string tag, input int restart_at);
    exp_t e;
    int   cyc, busy_cnt, extra;
    @(negedge CLK);
    chk({tag, ":idle"}, {30'd0, BUSY, DONE}, 32'd0);
    sb_q.push_back(model(a, b, tag));
    A = a; B = b; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    A = 6'($urandom); B = 6'($urandom);
    cyc = 1; busy_cnt = 0;
    while (!DONE && cyc < 40) begin
      if (BUSY) busy_cnt++;
      @(negedge CLK);
      cyc++;
      START = (cyc == restart_at);
    end
    START = 1'b0;
    e = sb_q.pop_front();
    chk({e.tag, ":done_seen"}, {31'd0, DONE}, 32'd1);
    chk({e.tag, ":latency"}, cyc, e.lat);
    chk({e.tag, ":busy_cycles"}, busy_cnt, e.lat - 1);
    chk({e.tag, ":busy_at_done"}, {31'd0, BUSY}, 32'd0);
    chk({e.tag, ":q"}, {26'd0, Q}, {26'd0, e.q});
    chk({e.tag, ":r"}, {26'd0, R}, {26'd0, e.r});
    chk({e.tag, ":div0"}, {31'd0, DIV0}, {31'd0, e.div0});
    chk({e.tag, ":of_div"}, {31'd0, OF_DIV}, {31'd0, e.ovf});
    if (restart_at > 0) begin
      extra = 0;
      repeat (12) begin
        @(negedge CLK);
        if (DONE) extra++;
      end
      chk({e.tag, ":no_extra_done"}, extra, 0);
      chk({e.tag, ":q_held"}, {26'd0, Q}, {26'd0, e.q});
    end
  endtask

  initial begin
    int cyc, dones;
    RST_N = 1'b0; START = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge CLK);
    chk("reset:outs", {20'd0, Q, R}, 32'd0);
    chk("reset:flags", {28'd0, DIV0, OF_DIV, BUSY, DONE}, 32'd0);
    RST_N = 1'b1;

    run_op(6'd13, 6'd4, "13/4", 0);
    run_op(6'b110011, 6'd4, "-13/4", 0);
    run_op(6'b010100, 6'b111101, "20/-3", 0);
    run_op(6'b100000, 6'b111111, "-32/-1", 0);
    run_op(6'd7, 6'd0, "7/0", 0);
    run_op(6'd9, 6'd3, "9/3", 0);
    run_op(6'b101100, 6'd6, "busy_restart", 3);

    // Asynchronous reset mid-operation aborts with no DONE
    @(negedge CLK);
    A = 6'd13; B = 6'd4; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    cyc = 1;
    while (cyc < 4) begin @(negedge CLK); cyc++; end
    RST_N = 1'b0;
    #1;
    chk("midreset:outs", {20'd0, Q, R}, 32'd0);
    chk("midreset:flags", {28'd0, DIV0, OF_DIV, BUSY, DONE}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    dones = 0;
    repeat (15) begin
      @(negedge CLK);
      if (DONE || BUSY) dones++;
    end
    chk("midreset:no_done", dones, 0);

    run_op(6'd5, 6'd5, "5/5", 0);
    run_op(6'd3, 6'd5, "3/5", 0);
    run_op(6'd0, 6'd7, "0/7", 0);
    run_op(6'b100000, 6'd1, "-32/1", 0);
    run_op(6'd31, 6'b100000, "31/-32", 0);
    run_op(6'b100000, 6'd0, "-32/0", 0);
    run_op(6'b100000, 6'b100000, "-32/-32", 0);
    for (int i = 0; i < 20; i++) begin
      logic [5:0] ra, rb;
      ra = 6'($urandom);
      rb = (i % 7 == 3) ? 6'd0 : 6'($urandom);
      run_op(ra, rb, $sformatf("rand%0d_%0h/%0h", i, ra, rb), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
